// File: rtl/shift_issue_ctrl_pkg.sv
// shift_issue_ctrl_pkg: shared state encoding, issue funct3 codes and the
// shift-class decode helper for the execute-stage shift sequencer.
package shift_issue_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_DONE,
        ST_DRAIN
    } state_e;

    localparam logic [2:0] FUNCT3_SLL = 3'b001;
    localparam logic [2:0] FUNCT3_SRX = 3'b101;

    function automatic logic is_shift_funct3(input logic [2:0] funct3);
        return (funct3 == FUNCT3_SLL) || (funct3 == FUNCT3_SRX);
    endfunction

endpackage

// File: rtl/shift_issue_ctrl_if.sv
// shift_issue_ctrl_if: operand/enable/result/busy bundle between the
// sequencer (master) and the multi-cycle shift unit (slave).
interface shift_issue_ctrl_if;

    logic [31:0] unit_a;
    logic [4:0]  unit_b;
    logic [2:0]  unit_funct3;
    logic        unit_op_alt;
    logic        unit_en;
    logic [31:0] unit_result;
    logic        unit_busy;

    modport master (
        output unit_a, unit_b, unit_funct3, unit_op_alt, unit_en,
        input  unit_result, unit_busy
    );

    modport slave (
        input  unit_a, unit_b, unit_funct3, unit_op_alt, unit_en,
        output unit_result, unit_busy
    );

endinterface

// File: rtl/shift_issue_ctrl.sv
// shift_issue_ctrl: execute-stage sequencer for a multi-cycle shift unit.
// Latches operands, runs the unit's enable/busy handshake, captures the
// result, stalls the front end meanwhile, handles flushes and a watchdog.
// Build option SHIFT_ISSUE_COMB_EN: single-cycle protocol for a combinational
// barrel unit (no LAUNCH/WAIT/DRAIN, no watchdog, o_err tied low).
module shift_issue_ctrl
    import shift_issue_ctrl_pkg::*;
#(
    parameter int unsigned WDOG_LIMIT = 40
) (
    input  logic                      i_clk_n,
    input  logic                      i_rst_n,
    input  logic                      i_valid,
    input  logic                      i_shift_en,
    input  logic [2:0]                i_funct3,
    input  logic                      i_op_alt,
    input  logic [31:0]               i_in_a,
    input  logic [4:0]                i_in_b,
    input  logic                      i_flush,
    shift_issue_ctrl_if.master        m_unit,
    output logic                      o_stall,
    output logic [31:0]               o_result,
    output logic                      o_result_valid,
    output logic                      o_err
);

    state_e      r_state;
    state_e      w_next;
    logic        w_issue;
    logic        w_unit_en;
    logic        w_capture;
    logic [31:0] r_result;

    assign w_issue        = i_valid && i_shift_en && is_shift_funct3(i_funct3) && !i_flush;
    assign o_result       = r_result;
    assign m_unit.unit_en = w_unit_en;

`ifdef SHIFT_ISSUE_COMB_EN
    assign m_unit.unit_a      = i_in_a;
    assign m_unit.unit_b      = i_in_b;
    assign m_unit.unit_funct3 = i_funct3;
    assign m_unit.unit_op_alt = i_op_alt;
    assign o_err              = 1'b0;

    // Single-cycle protocol: result is captured at the issue edge.
    always_comb begin
        w_next         = r_state;
        w_unit_en      = 1'b0;
        w_capture      = 1'b0;
        o_stall        = 1'b0;
        o_result_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_stall   = w_issue;
                w_unit_en = w_issue;
                if (w_issue) begin
                    w_capture = 1'b1;
                    w_next    = ST_DONE;
                end
            end
            ST_DONE: begin
                o_result_valid = !i_flush;
                w_next         = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end
`else
    localparam int unsigned WDOG_W = $clog2(WDOG_LIMIT + 1);

    logic [31:0]       r_unit_a;
    logic [4:0]        r_unit_b;
    logic [2:0]        r_unit_funct3;
    logic              r_unit_op_alt;
    logic [WDOG_W-1:0] r_wdog;
    logic              r_err;
    logic              w_load;
    logic              w_wdog_inc;
    logic              w_wdog_fire;

    assign m_unit.unit_a      = r_unit_a;
    assign m_unit.unit_b      = r_unit_b;
    assign m_unit.unit_funct3 = r_unit_funct3;
    assign m_unit.unit_op_alt = r_unit_op_alt;
    assign o_err              = r_err;

    // Next-state and handshake outputs; a flush overrides capture and watchdog.
    always_comb begin
        w_next         = r_state;
        w_unit_en      = 1'b0;
        w_capture      = 1'b0;
        w_load         = 1'b0;
        w_wdog_inc     = 1'b0;
        w_wdog_fire    = 1'b0;
        o_stall        = 1'b0;
        o_result_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_stall = w_issue;
                if (w_issue) begin
                    w_load = 1'b1;
                    w_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                o_stall = 1'b1;
                if (i_flush) begin
                    w_next = ST_DRAIN;
                end else begin
                    w_unit_en = 1'b1;
                    w_next    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                o_stall = 1'b1;
                if (i_flush) begin
                    w_next = ST_DRAIN;
                end else if (!m_unit.unit_busy) begin
                    w_capture = 1'b1;
                    w_next    = ST_DONE;
                end else begin
                    // Enable follows busy so SRA keeps sign-filling and the
                    // unit sees en low before it could reload.
                    w_unit_en = 1'b1;
                    if (r_wdog == WDOG_W'(WDOG_LIMIT - 1)) begin
                        w_wdog_fire = 1'b1;
                        w_next      = ST_IDLE;
                    end else begin
                        w_wdog_inc = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                o_result_valid = !i_flush;
                w_next         = ST_IDLE;
            end
            ST_DRAIN: begin
                o_stall = w_issue;
                if (!m_unit.unit_busy) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand latch, watchdog counter and sticky error flag.
    always_ff @(posedge i_clk_n or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_unit_a      <= '0;
            r_unit_b      <= '0;
            r_unit_funct3 <= '0;
            r_unit_op_alt <= 1'b0;
            r_wdog        <= '0;
            r_err         <= 1'b0;
        end else begin
            if (w_load) begin
                r_unit_a      <= i_in_a;
                r_unit_b      <= i_in_b;
                r_unit_funct3 <= i_funct3;
                r_unit_op_alt <= i_op_alt;
                r_wdog        <= '0;
            end
            if (w_wdog_inc) begin
                r_wdog <= r_wdog + WDOG_W'(1);
            end
            if (w_wdog_fire) begin
                r_err <= 1'b1;
            end
        end
    end
`endif

    // State register.
    always_ff @(posedge i_clk_n or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Result capture from the unit.
    always_ff @(posedge i_clk_n or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_result <= '0;
        end else if (w_capture) begin
            r_result <= m_unit.unit_result;
        end
    end

endmodule

// File: tb/tb_shift_issue_ctrl.sv
// tb_shift_issue_ctrl: randomized and directed checks of shift_issue_ctrl
// against a cycle-timeline reference model and a bench shift-unit model.
module tb_shift_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        i_shift_en;
    logic [2:0]  i_funct3;
    logic        i_op_alt;
    logic [31:0] i_in_a;
    logic [4:0]  i_in_b;
    logic        i_flush;
    logic        o_stall;
    logic [31:0] o_result;
    logic        o_result_valid;
    logic        o_err;

    int n_tests = 0;
    int n_fail  = 0;

    shift_issue_ctrl_if u_if ();

    shift_issue_ctrl #(.WDOG_LIMIT(40)) u_dut (
        .i_clk_n        (clk),
        .i_rst_n        (rst_n),
        .i_valid        (i_valid),
        .i_shift_en     (i_shift_en),
        .i_funct3       (i_funct3),
        .i_op_alt       (i_op_alt),
        .i_in_a         (i_in_a),
        .i_in_b         (i_in_b),
        .i_flush        (i_flush),
        .m_unit         (u_if),
        .o_stall        (o_stall),
        .o_result       (o_result),
        .o_result_valid (o_result_valid),
        .o_err          (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running, required finish");
        $fatal(1, "timeout");
    end

    // Architectural shift semantics.
    function automatic logic [31:0] ref_shift(input logic [2:0] f3, input logic alt,
                                              input logic [31:0] a, input logic [4:0] b);
        logic signed [31:0] sa;
        sa = a;
        if (f3 == 3'b001) return a << b;
        if (alt) return 32'(sa >>> b);
        return a >> b;
    endfunction

    // Bit-serial unit model: loads on en when idle, busy for b cycles.
    logic        um_running;
    logic [4:0]  um_rem;
    logic [31:0] um_result;
    logic        force_busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            um_running <= 1'b0;
            um_rem     <= '0;
            um_result  <= '0;
        end else if (!um_running && u_if.unit_en) begin
            um_result  <= ref_shift(u_if.unit_funct3, u_if.unit_op_alt, u_if.unit_a, u_if.unit_b);
            um_rem     <= u_if.unit_b;
            um_running <= (u_if.unit_b != 5'd0);
        end else if (um_running) begin
            um_rem <= um_rem - 5'd1;
            if (um_rem == 5'd1) um_running <= 1'b0;
        end
    end

    assign u_if.unit_busy   = um_running || force_busy;
    assign u_if.unit_result = um_result;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f3, input logic alt, input logic [31:0] a,
                         input logic [4:0] b);
        i_valid    = 1'b1;
        i_shift_en = 1'b1;
        i_funct3   = f3;
        i_op_alt   = alt;
        i_in_a     = a;
        i_in_b     = b;
        i_flush    = 1'b0;
    endtask

    // Issue in cycle 0 and hold ID/EX until the DONE cycle (N+3).
    task automatic run_shift(input string tag, input logic [2:0] f3, input logic alt,
                             input logic [31:0] a, input logic [4:0] b,
                             input logic [31:0] exp, input logic flush_done);
        int n;
        n = int'(b);
        drive(f3, alt, a, b);
        for (int c = 0; c <= n + 3; c++) begin
            @(negedge clk);
            check({tag, " stall"}, 32'(o_stall), 32'(c < n + 3));
            check({tag, " rvalid"}, 32'(o_result_valid), 32'((c == n + 3) && !flush_done));
            check({tag, " en"}, 32'(u_if.unit_en), 32'((c >= 1) && (c <= n + 1)));
            if (c == 1) begin
                check({tag, " unit_a"}, u_if.unit_a, a);
                check({tag, " unit_b"}, 32'(u_if.unit_b), 32'(b));
            end
            if (c == n + 3) check({tag, " result"}, o_result, exp);
            next_cycle();
            if (c + 1 == n + 3) i_flush = flush_done;
        end
        i_valid = 1'b0;
        i_flush = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " result"}, o_result, 32'h0);
        check({tag, " rvalid"}, 32'(o_result_valid), 32'h0);
        check({tag, " err"}, 32'(o_err), 32'h0);
        check({tag, " stall"}, 32'(o_stall), 32'h0);
        check({tag, " en"}, 32'(u_if.unit_en), 32'h0);
        check({tag, " unit_a"}, u_if.unit_a, 32'h0);
        check({tag, " unit_b"}, 32'(u_if.unit_b), 32'h0);
        check({tag, " unit_f3"}, 32'(u_if.unit_funct3), 32'h0);
        check({tag, " unit_alt"}, 32'(u_if.unit_op_alt), 32'h0);
    endtask

    initial begin
        logic [2:0]  f3;
        logic        alt;
        logic [31:0] a;
        logic [4:0]  b;
        logic        v;
        logic        se;
        logic        fl;

        rst_n = 1'b0;
        force_busy = 1'b0;
        i_valid = 1'b0; i_shift_en = 1'b0; i_funct3 = '0; i_op_alt = 1'b0;
        i_in_a = '0; i_in_b = '0; i_flush = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // Directed cases.
        run_shift("sll", 3'b001, 1'b0, 32'h0000_0001, 5'd4, 32'h0000_0010, 1'b0);
        run_shift("sra31", 3'b101, 1'b1, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0);
        run_shift("srl0", 3'b101, 1'b0, 32'h1234_5678, 5'd0, 32'h1234_5678, 1'b0);
        run_shift("srl31", 3'b101, 1'b0, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0);

        // Randomized back-to-back shifts, some flushed in DONE.
        for (int i = 0; i < 10; i++) begin
            f3  = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b101;
            alt = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = 5'($urandom_range(0, 31));
            fl  = ($urandom_range(0, 3) == 0);
            run_shift("rand", f3, alt, a, b, ref_shift(f3, alt, a, b), fl);
        end

        // Non-issuing patterns leave the sequencer idle.
        for (int i = 0; i < 8; i++) begin
            v  = 1'($urandom_range(0, 1));
            se = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            fl = 1'($urandom_range(0, 1));
            if (v && se && (f3 == 3'b001 || f3 == 3'b101)) fl = 1'b1;
            i_valid = v; i_shift_en = se; i_funct3 = f3; i_flush = fl;
            i_in_a = $urandom; i_in_b = 5'($urandom);
            @(negedge clk);
            check("noissue stall", 32'(o_stall), 32'h0);
            next_cycle();
            i_valid = 1'b0; i_flush = 1'b0;
            @(negedge clk);
            check("noissue en", 32'(u_if.unit_en), 32'h0);
            next_cycle();
        end

        // Flush during WAIT of SLL by 20, then a queued SRL.
        drive(3'b001, 1'b0, 32'h0000_0003, 5'd20);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("flush pre stall", 32'(o_stall), 32'h1);
            next_cycle();
        end
        i_flush = 1'b1;
        @(negedge clk);
        check("flush stall", 32'(o_stall), 32'h1);
        check("flush en", 32'(u_if.unit_en), 32'h0);
        check("flush rvalid", 32'(o_result_valid), 32'h0);
        next_cycle();
        drive(3'b101, 1'b0, 32'h0000_00F0, 5'd4);
        for (int c = 6; c <= 22; c++) begin
            @(negedge clk);
            check("drain stall", 32'(o_stall), 32'h1);
            check("drain en", 32'(u_if.unit_en), 32'h0);
            check("drain rvalid", 32'(o_result_valid), 32'h0);
            next_cycle();
        end
        run_shift("queued", 3'b101, 1'b0, 32'h0000_00F0, 5'd4, 32'h0000_000F, 1'b0);

        // Asynchronous reset pulse mid-WAIT.
        drive(3'b001, 1'b0, 32'h0000_0003, 5'd20);
        repeat (8) next_cycle();
        i_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_reset_state("midreset");
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        run_shift("postreset", 3'b101, 1'b1, 32'hF000_0000, 5'd8, 32'hFFF0_0000, 1'b0);

        // Hung unit: watchdog fires after 40 busy WAIT cycles.
        force_busy = 1'b1;
        drive(3'b001, 1'b0, 32'h0000_0001, 5'd3);
        for (int c = 0; c <= 41; c++) begin
            @(negedge clk);
            check("wdog stall", 32'(o_stall), 32'h1);
            check("wdog err early", 32'(o_err), 32'h0);
            check("wdog en", 32'(u_if.unit_en), 32'(c >= 1));
            next_cycle();
        end
        i_valid = 1'b0;
        @(negedge clk);
        check("wdog err", 32'(o_err), 32'h1);
        check("wdog idle stall", 32'(o_stall), 32'h0);
        check("wdog idle en", 32'(u_if.unit_en), 32'h0);
        next_cycle();
        force_busy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("err sticky", 32'(o_err), 32'h1);
            next_cycle();
        end
        rst_n = 1'b0;
        #1 check("err cleared", 32'(o_err), 32'h0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        run_shift("recover", 3'b001, 1'b1, 32'h8000_0001, 5'd1, 32'h0000_0002, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
